// File: rtl/blue_seq_ctrl.sv
// Blue instruction sequencer: fetches over a req/ack port, holds the A/B/ZNC
// architectural registers, and sequences FETCH/DECODE/EXEC/WB.
module blue_seq_ctrl #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      alu_sel,
  output logic [15:0]     a_q,
  output logic [15:0]     b_q,
  output logic [2:0]      znc_q,
  input  logic [15:0]     deco_a,
  input  logic [15:0]     deco_b,
  input  logic [2:0]      deco_znc,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    C_ALU  = 2'b00,
    C_LDB  = 2'b01,
    C_BR   = 2'b10,
    C_HALT = 2'b11
  } iclass_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [15:0]     r_ir;
  logic [15:0]     r_a;
  logic [15:0]     r_b;
  logic [2:0]      r_znc;
  logic [2:0]      r_alu_sel;
  logic [PC_W-1:0] r_pc;

  iclass_t         w_class;
  logic [2:0]      w_mask;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_taken;
  logic            w_restart;
  logic            w_ir_load;
  logic            w_sel_load;
  logic            w_wb;
  logic            w_unused_ir;

  assign w_class     = iclass_t'(r_ir[15:14]);
  assign w_mask      = r_ir[10:8];
  assign w_target    = r_ir[PC_W-1:0];
  assign w_pc_inc    = r_pc + PC_ONE;
  // Flags tested here are the ones held before this WB's own update.
  assign w_taken     = (w_mask == 3'b000) || ((r_znc & w_mask) != 3'b000);
  assign w_unused_ir = ^r_ir[13:12];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    w_ir_load    = 1'b0;
    w_sel_load   = 1'b0;
    w_wb         = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_restart    = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_next_state = S_DECODE;
          w_ir_load    = 1'b1;
        end
      end
      S_DECODE: w_next_state = (w_class == C_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        w_next_state = S_WB;
        w_sel_load   = (w_class == C_ALU);
      end
      S_WB: begin
        w_next_state = S_FETCH;
        w_wb         = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RST_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_znc     <= '0;
      r_alu_sel <= '0;
    end else begin
      if (w_restart)  r_pc      <= RST_PC;
      if (w_ir_load)  r_ir      <= imem_data;
      if (w_sel_load) r_alu_sel <= r_ir[2:0];
      if (w_wb) begin
        case (w_class)
          C_ALU: begin
            r_a   <= deco_a;
            r_b   <= deco_b;
            r_znc <= deco_znc;
            r_pc  <= w_pc_inc;
          end
          C_LDB: begin
            r_b  <= {4'b0000, r_ir[11:0]};
            r_pc <= w_pc_inc;
          end
          C_BR:    r_pc <= w_taken ? w_target : w_pc_inc;
          default: r_pc <= w_pc_inc;
        endcase
      end
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign alu_sel   = r_alu_sel;
  assign a_q       = r_a;
  assign b_q       = r_b;
  assign znc_q     = r_znc;
  assign pc        = r_pc;
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_blue_seq_ctrl.sv
// Bench for blue_seq_ctrl: program tables with a scoreboard of post-WB state,
// an ALU/flag model for the decoder stage, and hand sequences for corner cases.
module tb_blue_seq_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  znc;
    logic [2:0]  sel;
    logic        halt;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  znc;
    logic [2:0]  sel;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack;
  logic [15:0] imem_data;
  logic        imem_req, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic [2:0]  alu_sel, znc_q, deco_znc;
  logic [15:0] a_q, b_q, deco_a, deco_b;

  logic        start2, req2, ack2, busy2, halted2;
  logic [3:0]  addr2, pc2;
  logic [15:0] data2, a2, b2;
  logic [2:0]  sel2, znc2;

  always #5 clk = ~clk;

  blue_seq_ctrl #(.PC_W(8), .RST_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_sel(alu_sel), .a_q(a_q), .b_q(b_q), .znc_q(znc_q),
    .deco_a(deco_a), .deco_b(deco_b), .deco_znc(deco_znc),
    .pc(pc), .busy(busy), .halted(halted)
  );

  blue_seq_ctrl #(.PC_W(4), .RST_PC(4'hF)) dut_w4 (
    .clk(clk), .rst(rst), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_data(data2),
    .alu_sel(sel2), .a_q(a2), .b_q(b2), .znc_q(znc2),
    .deco_a(16'h0000), .deco_b(16'h0000), .deco_znc(3'b000),
    .pc(pc2), .busy(busy2), .halted(halted2)
  );

  // Zero-wait memory for the 4-bit-PC instance: LDB 3 at 15, HALT elsewhere.
  assign ack2  = req2;
  assign data2 = (addr2 == 4'hF) ? 16'h4003 : 16'hC000;

  // Decoder-stage model: MOV/OR/AND/XOR/ADD/SUB/SHR/EXCH by alu_sel.
  function automatic logic [34:0] alu_model(input logic [2:0] sel, input logic [15:0] a,
                                             input logic [15:0] b, input logic [2:0] f);
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic [2:0]  rf;
    ra = a; rb = b; rf = f; r = '0;
    case (sel)
      3'd0: ra = b;
      3'd1: begin ra = a | b; rf = {(ra == 16'h0), ra[15], 1'b0}; end
      3'd2: begin ra = a & b; rf = {(ra == 16'h0), ra[15], 1'b0}; end
      3'd3: begin ra = a ^ b; rf = {(ra == 16'h0), ra[15], 1'b0}; end
      3'd4: begin r = {1'b0, a} + {1'b0, b}; ra = r[15:0]; rf = {(ra == 16'h0), ra[15], r[16]}; end
      3'd5: begin r = {1'b0, a} - {1'b0, b}; ra = r[15:0]; rf = {(ra == 16'h0), ra[15], r[16]}; end
      3'd6: ra = a >> 1;
      default: begin ra = b; rb = a; end
    endcase
    return {ra, rb, rf};
  endfunction

  always_comb begin
    {deco_a, deco_b, deco_znc} = alu_model(alu_sel, a_q, b_q, znc_q);
  end

  int          n_checks = 0;
  int          n_errors = 0;
  vec_t        tbl[$];
  exp_t        sb[$];
  logic [15:0] mem [256];
  logic [3:0]  addr2_log[$];

  int          cyc = 0;
  int          last_entry = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          since_ack = -1;
  bit          stray_en = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_busy = 1'b0;
  bit          prev_req2 = 1'b0;
  logic [7:0]  fetch_addr;
  logic [34:0] saved_regs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] addr, input logic [15:0] instr, input logic [7:0] npc,
                     input logic [15:0] a, input logic [15:0] b, input logic [2:0] znc,
                     input logic [2:0] sel);
    vec_t v;
    v.addr = addr; v.instr = instr; v.pc = npc; v.a = a; v.b = b;
    v.znc = znc; v.sel = sel; v.halt = (instr[15:14] == 2'b11);
    tbl.push_back(v);
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
    foreach (tbl[i]) mem[tbl[i].addr] = tbl[i].instr;
  endtask

  // One cycle: memory responder, ignored-input injection and scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    start     = 1'b0;
    start2    = 1'b0;
    imem_ack  = 1'b0;
    if (since_ack >= 0) since_ack++;
    if (stray_en && since_ack == 1) begin
      imem_ack  = 1'b1;
      imem_data = 16'hC000;
    end
    if (stray_en && since_ack == 2) begin
      start    = 1'b1;
      stray_en = 1'b0;
    end
    if (since_ack >= 3) since_ack = -1;

    if (imem_req && !prev_req) begin
      if (prev_busy) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          check("wb_pc",     64'(pc),    64'(e.pc));
          check("wb_a",      64'(a_q),   64'(e.a));
          check("wb_b",      64'(b_q),   64'(e.b));
          check("wb_znc",    64'(znc_q), 64'(e.znc));
          check("wb_alusel", 64'(alu_sel), 64'(e.sel));
          check("instr_cycles", 64'(cyc - last_entry), 64'(e.cycles));
        end
      end
      last_entry = cyc;
      fetch_addr = imem_addr;
      saved_regs = {a_q, b_q, znc_q};
      wait_cnt   = 0;
    end else if (imem_req) begin
      check("fetch_hold", 64'({imem_addr, a_q, b_q, znc_q}), 64'({fetch_addr, saved_regs}));
    end

    if (imem_req) begin
      if (wait_cnt == wait_cfg) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        since_ack = 0;
        foreach (tbl[i]) begin
          if (tbl[i].addr == imem_addr && !tbl[i].halt) begin
            e.pc = tbl[i].pc; e.a = tbl[i].a; e.b = tbl[i].b;
            e.znc = tbl[i].znc; e.sel = tbl[i].sel; e.cycles = 4 + wait_cfg;
            sb.push_back(e);
          end
        end
      end else begin
        wait_cnt++;
      end
    end

    if (req2 && !prev_req2) addr2_log.push_back(addr2);
    prev_req  = imem_req;
    prev_busy = busy;
    prev_req2 = req2;
  endtask

  task automatic run_to_halt(input logic [7:0] halt_pc);
    for (int g = 0; g < 600 && !halted; g++) tick();
    check("halted",      64'(halted),    64'(1));
    check("halt_busy",   64'(busy),      64'(0));
    check("halt_pc",     64'(pc),        64'(halt_pc));
    check("halt_req",    64'(imem_req),  64'(0));
    check("sb_drained",  64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; imem_ack = 1'b0; imem_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_pc",     64'(pc),       64'(0));
    check("rst_a",      64'(a_q),      64'(0));
    check("rst_b",      64'(b_q),      64'(0));
    check("rst_znc",    64'(znc_q),    64'(0));
    check("rst_alusel", 64'(alu_sel),  64'(0));
    check("rst_req",    64'(imem_req), 64'(0));
    check("rst_busy",   64'(busy),     64'(0));
    check("rst_halted", 64'(halted),   64'(0));

    // Program 1, zero-wait: LDB/ALU mix, taken/not-taken/unconditional branches.
    //   addr  instr    next_pc a       b       znc     alu_sel
    add(8'h00, 16'h4005, 8'h01, 16'h0000, 16'h0005, 3'b000, 3'd0);
    add(8'h01, 16'h0004, 8'h02, 16'h0005, 16'h0005, 3'b000, 3'd4);
    add(8'h02, 16'h4FFF, 8'h03, 16'h0005, 16'h0FFF, 3'b000, 3'd4);
    add(8'h03, 16'h0005, 8'h04, 16'hF006, 16'h0FFF, 3'b011, 3'd5);
    add(8'h04, 16'h8110, 8'h10, 16'hF006, 16'h0FFF, 3'b011, 3'd5);
    add(8'h10, 16'h8410, 8'h11, 16'hF006, 16'h0FFF, 3'b011, 3'd5);
    add(8'h11, 16'h8020, 8'h20, 16'hF006, 16'h0FFF, 3'b011, 3'd5);
    add(8'h20, 16'h0003, 8'h21, 16'hFFF9, 16'h0FFF, 3'b010, 3'd3);
    add(8'h21, 16'h0007, 8'h22, 16'h0FFF, 16'hFFF9, 3'b010, 3'd7);
    add(8'h22, 16'h0002, 8'h23, 16'h0FF9, 16'hFFF9, 3'b000, 3'd2);
    add(8'h23, 16'h0005, 8'h24, 16'h1000, 16'hFFF9, 3'b001, 3'd5);
    add(8'h24, 16'h4000, 8'h25, 16'h1000, 16'h0000, 3'b001, 3'd5);
    add(8'h25, 16'h0006, 8'h26, 16'h0800, 16'h0000, 3'b001, 3'd6);
    add(8'h26, 16'h0002, 8'h27, 16'h0000, 16'h0000, 3'b100, 3'd2);
    add(8'h27, 16'h4123, 8'h28, 16'h0000, 16'h0123, 3'b100, 3'd2);
    add(8'h28, 16'h0000, 8'h29, 16'h0123, 16'h0123, 3'b100, 3'd0);
    add(8'h29, 16'h8430, 8'h30, 16'h0123, 16'h0123, 3'b100, 3'd0);
    add(8'h30, 16'h8130, 8'h31, 16'h0123, 16'h0123, 3'b100, 3'd0);
    add(8'h31, 16'hC000, 8'h31, 16'h0123, 16'h0123, 3'b100, 3'd0);
    load_mem();
    wait_cfg = 0;
    start = 1'b1;
    tick();
    check("start_req",  64'(imem_req),  64'(1));
    check("start_addr", 64'(imem_addr), 64'(0));
    run_to_halt(8'h31);

    // Program 2 after restart from HALT: 3 wait states per fetch, registers
    // retained, stray ack in DECODE and start in EXEC of the first instruction.
    tbl.delete();
    add(8'h00, 16'h4007, 8'h01, 16'h0123, 16'h0007, 3'b100, 3'd0);
    add(8'h01, 16'h0001, 8'h02, 16'h0127, 16'h0007, 3'b000, 3'd1);
    add(8'h02, 16'h0007, 8'h03, 16'h0007, 16'h0127, 3'b000, 3'd7);
    add(8'h03, 16'h0004, 8'h04, 16'h012E, 16'h0127, 3'b000, 3'd4);
    add(8'h04, 16'h8006, 8'h06, 16'h012E, 16'h0127, 3'b000, 3'd4);
    add(8'h06, 16'hC000, 8'h06, 16'h012E, 16'h0127, 3'b000, 3'd4);
    load_mem();
    wait_cfg = 3;
    stray_en = 1'b1;
    start = 1'b1;
    tick();
    run_to_halt(8'h06);

    // Reset asserted while a fetch is waiting on ack.
    wait_cfg = 10;
    start = 1'b1;
    repeat (3) tick();
    check("pre_rst_req", 64'(imem_req), 64'(1));
    check("retain_a",    64'(a_q),      64'(16'h012E));
    rst = 1'b1;
    #1;
    check("midfetch_rst_req", 64'(imem_req), 64'(0));
    check("midfetch_rst_pc",  64'(pc),       64'(0));
    check("midfetch_rst_ab",  64'({a_q, b_q}), 64'(0));
    check("midfetch_rst_znc", 64'(znc_q),    64'(0));
    tick();
    rst = 1'b0;
    sb.delete();
    tick();
    start = 1'b1;
    tick();
    check("restart_req",  64'(imem_req),  64'(1));
    check("restart_addr", 64'(imem_addr), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    tick();

    // 4-bit PC: start at 15, non-branch wraps the next fetch to 0, then HALT.
    start2 = 1'b1;
    tick();
    for (int g = 0; g < 50 && !halted2; g++) tick();
    check("w4_halted",  64'(halted2),          64'(1));
    check("w4_busy",    64'(busy2),            64'(0));
    check("w4_fetches", 64'(addr2_log.size()), 64'(2));
    if (addr2_log.size() == 2) begin
      check("w4_first_addr", 64'(addr2_log[0]), 64'(4'hF));
      check("w4_wrap_addr",  64'(addr2_log[1]), 64'(4'h0));
    end
    check("w4_pc",   64'(pc2), 64'(4'h0));
    check("w4_b",    64'(b2),  64'(16'h0003));
    check("w4_azs",  64'({a2, znc2, sel2}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
